// File: rtl/fetch_unit_pkg.sv
// Shared processor package: PC source codes, NOP, fetch FSM states.
// Common to fetch and decode.
package fetch_unit_pkg;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } fetch_state_t;

  function automatic logic is_misaligned(
    input logic [31:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC mux and adders.
// FETCH_MISALIGN_TRAP_EN: misaligned targets redirect to TRAP_VECTOR.
module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        trap
);

  logic [31:0] pc_imm;
  logic [31:0] target;

  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + imm;

  // Raw target selected by the PC source code.
  always_comb begin
    target = pc_plus4;
    unique case (1'b1)
      pc_src == PC_PLUS4:  target = pc_plus4;
      pc_src == PC_BRANCH: target = branch_taken ? pc_imm : pc_plus4;
      pc_src == PC_JAL:    target = pc_imm;
      pc_src == PC_JALR:   target = {alu_result[31:1], 1'b0};
      default:             target = pc_plus4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misaligned target redirects to the trap vector.
  always_comb begin
    trap    = is_misaligned(target);
    next_pc = trap ? TRAP_VECTOR : target;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TRAP_VECTOR;

  // Misaligned target is silently word-aligned.
  always_comb begin
    trap    = 1'b0;
    next_pc = {target[31:2], 2'b00};
  end
`endif

  logic unused_alu;
  assign unused_alu = alu_result[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request/valid FSM, PC, instr and retire count.
// FETCH_MISALIGN_TRAP_EN enables the misaligned-target trap.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned,
  output logic [31:0] retired
);

  fetch_state_t state;
  fetch_state_t state_n;
  logic         take;
  logic         adv;
  logic [31:0]  next_pc;
  logic         trap;

  next_pc_calc #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_npc (
    .pc           (pc),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm          (imm),
    .alu_result   (alu_result),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .trap         (trap)
  );

  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_n;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n     = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    take        = 1'b0;
    adv         = 1'b0;
    unique case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          take    = 1'b1;
          state_n = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          adv     = 1'b1;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  // PC, instruction latch, retire count and trap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instr      <= NOP_INSTR;
      retired    <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= adv & trap;
      if (take) begin
        instr <= imem_rdata;
      end
      if (adv) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus random
// transactions checked against a spec-level next-PC model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TRAPV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic [31:0] retired;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm          (imm),
    .alu_result   (alu_result),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misaligned   (misaligned),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
  } fexp_t;

  fexp_t fq[$];
  logic  mq[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc = 32'd0;
  logic [31:0] mret = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Next PC from the architectural rules, in plain arithmetic.
  task automatic model_next(input logic [1:0] src, input logic tk,
                            input logic [31:0] im, input logic [31:0] al,
                            output logic [31:0] np, output logic mis);
    logic [31:0] t;
    case (src)
      2'd0: t = mpc + 4;
      2'd1: t = tk ? mpc + im : mpc + 4;
      2'd2: t = mpc + im;
      default: t = al - (al % 2);
    endcase
    mis = 1'b0;
    np  = t;
    if (t % 4 != 0) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      np  = TRAPV;
      mis = 1'b1;
`else
      np  = t - (t % 4);
`endif
    end
  endtask

  task automatic do_fetch(input int dly, input logic [31:0] data);
    logic [31:0] a0;
    a0 = imem_addr;
    for (int i = 0; i < dly; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      exec_done  = 1'($urandom % 2);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, mpc);
      chk("stall_addr_const", imem_addr, a0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    exec_done  = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = data;
    fq.push_back('{pc: mpc, instr: data, ret: mret});
    @(posedge clk); #1;
    imem_ready = 1'($urandom % 2);
    imem_rdata = $urandom;
    chk("fetch_latency", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic do_exec(input int hold, input logic [1:0] src,
                         input logic tk, input logic [31:0] im,
                         input logic [31:0] al);
    logic [31:0] np;
    logic        mis;
    for (int i = 0; i < hold; i++) begin
      pc_src       = 2'($urandom);
      branch_taken = 1'($urandom);
      imm          = $urandom;
      alu_result   = $urandom;
      @(posedge clk); #1;
      imem_ready = 1'($urandom % 2);
      chk("hold_pc", pc, mpc);
    end
    pc_src       = src;
    branch_taken = tk;
    imm          = im;
    alu_result   = al;
    exec_done    = 1'b1;
    model_next(src, tk, im, al, np, mis);
    mq.push_back(mis);
    @(posedge clk); #1;
    exec_done  = 1'b0;
    imem_ready = 1'b0;
    mpc  = np;
    mret = mret + 1;
    chk("pc_update", pc, mpc);
    chk("retired_update", retired, mret);
  endtask

  // Monitor: checks each newly presented instruction and the
  // cycle following every accepted exec_done.
  logic prev_v = 1'b0;
  logic mis_pend = 1'b0;
  always @(negedge clk) begin
    fexp_t e;
    logic  em;
    if (!rst_n) begin
      prev_v   = 1'b0;
      mis_pend = 1'b0;
    end else begin
      if (mis_pend) begin
        mis_pend = 1'b0;
        if (mq.size() == 0) begin
          chk("mis_queue_empty", 32'd0, 32'd1);
        end else begin
          em = mq.pop_front();
          chk("misaligned", {31'd0, misaligned}, {31'd0, em});
          chk("post_exec_valid", {31'd0, instr_valid}, 32'd0);
          chk("post_exec_req", {31'd0, imem_req}, 32'd1);
        end
      end else begin
        chk("misaligned_idle", {31'd0, misaligned}, 32'd0);
      end
      if (instr_valid && !prev_v) begin
        if (fq.size() == 0) begin
          chk("fetch_queue_empty", 32'd0, 32'd1);
        end else begin
          e = fq.pop_front();
          chk("instr", instr, e.instr);
          chk("pc", pc, e.pc);
          chk("pc_plus4", pc_plus4, e.pc + 4);
          chk("retired", retired, e.ret);
          chk("valid_req", {31'd0, imem_req}, 32'd0);
        end
      end
      if (instr_valid && exec_done) mis_pend = 1'b1;
      prev_v = instr_valid;
    end
  end

  initial begin
    logic [31:0] im;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset_instr", instr, NOP);
    rst_n = 1'b1;
    mpc = 32'd0;
    mret = 32'd0;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    chk("rel_retired", retired, 32'd0);

    // Reset release with immediate ready; jump to 0x10.
    do_fetch(0, 32'hDEAD_BEEF);
    do_exec(1, 2'b10, 1'b0, 32'h10, 32'd0);
    // Sequential 0x10 -> 0x14.
    do_fetch(1, 32'h0000_0093);
    do_exec(0, 2'b00, 1'b0, 32'd0, 32'd0);
    chk("seq_pc", pc, 32'h14);
    // To 0x20, branch taken -8 -> 0x18.
    do_fetch(0, $urandom);
    do_exec(0, 2'b10, 1'b0, 32'h0C, 32'd0);
    do_fetch(0, $urandom);
    do_exec(2, 2'b01, 1'b1, 32'hFFFF_FFF8, 32'd0);
    chk("br_taken_pc", pc, 32'h18);
    // Back to 0x20, branch not taken -> 0x24.
    do_fetch(0, $urandom);
    do_exec(0, 2'b10, 1'b0, 32'h8, 32'd0);
    do_fetch(0, $urandom);
    do_exec(0, 2'b01, 1'b0, 32'hFFFF_FFF8, 32'd0);
    chk("br_not_taken_pc", pc, 32'h24);
    // JALR to misaligned 0x1003.
    do_fetch(0, $urandom);
    do_exec(0, 2'b11, 1'b0, 32'd0, 32'h0000_1003);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("jalr_trap_pc", pc, TRAPV);
`else
    chk("jalr_align_pc", pc, 32'h1000);
`endif
    // Five-cycle stall.
    do_fetch(5, $urandom);
    do_exec(0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      im = 32'(($urandom % 64) * 4) - 32'd128;
      if ($urandom % 5 == 0) im = im + 32'(1 + $urandom % 3);
      do_fetch($urandom % 4, $urandom);
      do_exec($urandom % 3, 2'($urandom), 1'($urandom),
              im, $urandom);
    end

    // Reach 0x40, then reset while instruction is valid.
    do_fetch(0, $urandom);
    do_exec(0, 2'b11, 1'b0, 32'd0, 32'h0000_0041);
    chk("pre_rst_pc", pc, 32'h40);
    do_fetch(1, $urandom);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'd0);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_retired", retired, 32'd0);
    chk("async_rst_instr", instr, NOP);
    chk("async_rst_mis", {31'd0, misaligned}, 32'd0);
    fq.delete();
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mpc  = 32'd0;
    mret = 32'd0;
    chk("rel2_addr", imem_addr, 32'd0);
    for (int n = 0; n < 5; n++) begin
      do_fetch($urandom % 3, $urandom);
      do_exec($urandom % 2, 2'($urandom), 1'($urandom),
              32'($urandom % 16) * 4, $urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("mq_drained", 32'(mq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
